// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU: valid/ready handshake, shift-add multiply, restoring divide.
// Optional signed greater-than on opcode 14 when SEQ_ALU_SIGNED_CMP_EN is defined.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_result_hi,
    output logic             zero,
    output logic             carry,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_mul_q;
    logic [WIDTH-1:0]   operand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic               zero_q;
    logic               carry_q;
    logic               dbz_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [WIDTH-1:0]   res_d;
    logic [WIDTH-1:0]   hi_d;
    logic               carry_d;
    logic               dbz_d;
    logic               zero_d;
    logic               reserved_d;
    logic               multi_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_fits;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] step_acc;

    // Results of every opcode that finishes in the accept cycle.
    always_comb begin
        res_d      = '0;
        hi_d       = '0;
        carry_d    = 1'b0;
        dbz_d      = 1'b0;
        reserved_d = 1'b0;
        case (alu_control)
            4'd0:  {carry_d, res_d} = {1'b0, src_a} + {1'b0, src_b};
            4'd1:  begin
                res_d   = src_a - src_b;
                carry_d = (src_a < src_b);
            end
            4'd3:  begin
                hi_d  = src_a;
                dbz_d = 1'b1;
            end
            4'd4:  res_d = src_a & src_b;
            4'd5:  res_d = src_a | src_b;
            4'd6:  res_d = ~src_a;
            4'd7:  res_d = src_a ^ src_b;
            4'd8:  res_d = {1'b0, src_a[WIDTH-1:1]};
            4'd9:  res_d = {src_a[WIDTH-2:0], 1'b0};
            4'd10: res_d = {src_a[WIDTH-2:0], src_a[WIDTH-1]};
            4'd11: res_d = {src_a[0], src_a[WIDTH-1:1]};
            4'd12: res_d = {{(WIDTH-1){1'b0}}, (src_a > src_b)};
            4'd13: res_d = {{(WIDTH-1){1'b0}}, (src_a == src_b)};
`ifdef SEQ_ALU_SIGNED_CMP_EN
            4'd14: res_d = {{(WIDTH-1){1'b0}}, ($signed(src_a) > $signed(src_b))};
`endif
            default: reserved_d = 1'b1;
        endcase
        zero_d  = !reserved_d && (res_d == '0);
        multi_d = (alu_control == OP_MUL) || ((alu_control == OP_DIV) && (src_b != '0));
    end

    // One multiply or divide iteration; acc_q holds {hi, lo} = {partial/remainder, multiplier/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, operand_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, operand_q});
        div_rem   = div_fits ? (div_shift[WIDTH-1:0] - operand_q) : div_shift[WIDTH-1:0];
        if (is_mul_q) begin
            step_acc = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            step_acc = {div_rem, acc_q[WIDTH-2:0], div_fits};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_mul_q    <= 1'b0;
            operand_q   <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        if (multi_d) begin
                            state_q   <= BUSY;
                            cnt_q     <= CNT_W'(WIDTH);
                            is_mul_q  <= (alu_control == OP_MUL);
                            operand_q <= (alu_control == OP_MUL) ? src_a : src_b;
                            acc_q     <= {{WIDTH{1'b0}}, (alu_control == OP_MUL) ? src_b : src_a};
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= res_d;
                            result_hi_q <= hi_d;
                            zero_q      <= zero_d;
                            carry_q     <= carry_d;
                            dbz_q       <= dbz_d;
                        end
                    end
                end
                BUSY: begin
                    acc_q <= step_acc;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= step_acc[WIDTH-1:0];
                        result_hi_q <= step_acc[2*WIDTH-1:WIDTH];
                        zero_q      <= (step_acc[WIDTH-1:0] == '0);
                        carry_q     <= 1'b0;
                        dbz_q       <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign alu_result    = result_q;
    assign alu_result_hi = result_hi_q;
    assign zero          = zero_q;
    assign carry         = carry_q;
    assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, handshake corner cases,
// and randomized operations against an arithmetic reference model.
module tb_seq_alu;

   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  src_a;
   logic [W-1:0]  src_b;
   logic [3:0]    alu_control;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  alu_result;
   logic [W-1:0]  alu_result_hi;
   logic          zero;
   logic          carry;
   logic          div_by_zero;

   int vectorCount = 0;
   int missCount   = 0;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         z;
      logic         c;
      logic         d;
      int           lat;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         z;
      logic         c;
      logic         d;
      int           lat;
      bit           readyHigh;
      bit           unstable;
      bit           released;
   } obs_t;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .src_a(src_a),
      .src_b(src_b),
      .alu_control(alu_control),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .alu_result(alu_result),
      .alu_result_hi(alu_result_hi),
      .zero(zero),
      .carry(carry),
      .div_by_zero(div_by_zero)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   // Single comparison point: bumps the counters and reports any difference.
   task automatic checkOutput(input string name, input longint got, input longint exp);
      vectorCount++;
      if (got != exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference behaviour derived from the opcode definitions with plain integer arithmetic.
   function automatic vec_t refModel(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      vec_t   e;
      longint ua, ub, m, r, h, sa, sb;
      bit     reserved;
      ua = longint'(a);
      ub = longint'(b);
      m = 64'd1 << W;
      r = 0; h = 0; reserved = 0;
      e.op = op; e.a = a; e.b = b; e.c = 0; e.d = 0; e.lat = 1;
      case (op)
         4'd0:  begin r = (ua + ub) % m; e.c = ((ua + ub) >= m); end
         4'd1:  begin r = (ua - ub + m) % m; e.c = (ua < ub); end
         4'd2:  begin r = (ua * ub) % m; h = (ua * ub) / m; e.lat = W + 1; end
         4'd3:  begin
            if (ub == 0) begin r = 0; h = ua; e.d = 1; end
            else begin r = ua / ub; h = ua % ub; e.lat = W + 1; end
         end
         4'd4:  r = ua & ub;
         4'd5:  r = ua | ub;
         4'd6:  r = (m - 1) - ua;
         4'd7:  r = ua ^ ub;
         4'd8:  r = ua / 2;
         4'd9:  r = (ua * 2) % m;
         4'd10: r = (ua * 2) % m + ua / (m / 2);
         4'd11: r = ua / 2 + (ua % 2) * (m / 2);
         4'd12: r = (ua > ub) ? 1 : 0;
         4'd13: r = (ua == ub) ? 1 : 0;
`ifdef SEQ_ALU_SIGNED_CMP_EN
         4'd14: begin
            sa = (ua >= m / 2) ? ua - m : ua;
            sb = (ub >= m / 2) ? ub - m : ub;
            r = (sa > sb) ? 1 : 0;
         end
`endif
         default: reserved = 1;
      endcase
      e.res = r[W-1:0];
      e.hi  = h[W-1:0];
      e.z   = !reserved && (r == 0);
      return e;
   endfunction

   // Issue one request, wait for the result, hold it for 'hold' cycles, then consume it.
   task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input int hold, output obs_t o);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      alu_control = op;
      src_a       = a;
      src_b       = b;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid    = 1'b0;
      src_a       = W'($urandom);
      src_b       = W'($urandom);
      alu_control = 4'($urandom);
      o.lat = 1;
      o.readyHigh = 0;
      o.unstable = 0;
      while (!out_valid && o.lat < 40) begin
         if (in_ready) o.readyHigh = 1;
         @(posedge clk); #1;
         o.lat++;
      end
      if (in_ready) o.readyHigh = 1;
      o.res = alu_result;
      o.hi  = alu_result_hi;
      o.z   = zero;
      o.c   = carry;
      o.d   = div_by_zero;
      repeat (hold) begin
         @(posedge clk); #1;
         if (in_ready || !out_valid || alu_result != o.res || alu_result_hi != o.hi) o.unstable = 1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      o.released = in_ready && !out_valid;
   endtask

   task automatic runVector(input string tag, input vec_t e, input int hold);
      obs_t o;
      applyStimulus(e.op, e.a, e.b, hold, o);
      checkOutput({tag, " result"},    o.res, e.res);
      checkOutput({tag, " result_hi"}, o.hi,  e.hi);
      checkOutput({tag, " zero"},      o.z,   e.z);
      checkOutput({tag, " carry"},     o.c,   e.c);
      checkOutput({tag, " div0"},      o.d,   e.d);
      checkOutput({tag, " latency"},   o.lat, e.lat);
      checkOutput({tag, " busyReady"}, o.readyHigh, 0);
      checkOutput({tag, " hold"},      o.unstable, 0);
      checkOutput({tag, " release"},   o.released, 1);
   endtask

   vec_t tbl[16];

   initial begin
      bit   sawValid;
      bit   bad;
      vec_t e;
      obs_t o;

      tbl[0]  = '{4'd0,  8'hF0, 8'h20, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1};
      tbl[1]  = '{4'd1,  8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1};
      tbl[2]  = '{4'd1,  8'h03, 8'h05, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1};
      tbl[3]  = '{4'd2,  8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 9};
      tbl[4]  = '{4'd2,  8'h10, 8'h10, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 9};
      tbl[5]  = '{4'd3,  8'd200, 8'd7, 8'd28, 8'd4,  1'b0, 1'b0, 1'b0, 9};
      tbl[6]  = '{4'd3,  8'h55, 8'h00, 8'h00, 8'h55, 1'b1, 1'b0, 1'b1, 1};
      tbl[7]  = '{4'd3,  8'h03, 8'h09, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0, 9};
      tbl[8]  = '{4'd10, 8'h81, 8'h00, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1};
      tbl[9]  = '{4'd11, 8'h81, 8'h00, 8'hC0, 8'h00, 1'b0, 1'b0, 1'b0, 1};
      tbl[10] = '{4'd8,  8'h81, 8'h00, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1};
      tbl[11] = '{4'd9,  8'h81, 8'h00, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1};
      tbl[12] = '{4'd6,  8'h0F, 8'h00, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1};
      tbl[13] = '{4'd13, 8'h07, 8'h06, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1};
`ifdef SEQ_ALU_SIGNED_CMP_EN
      tbl[14] = '{4'd14, 8'h01, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1};
`else
      tbl[14] = '{4'd14, 8'h01, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1};
`endif
      tbl[15] = '{4'd15, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      src_a = '0; src_b = '0; alu_control = '0;

      // Reset state: everything low while rst_n is asserted, ready one cycle after release.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset in_ready",  in_ready,  0);
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset result",    alu_result, 0);
      checkOutput("reset result_hi", alu_result_hi, 0);
      checkOutput("reset flags",     {zero, carry, div_by_zero}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("release in_ready", in_ready, 1);

      // Directed vectors, including a result held under backpressure for a few cycles.
      foreach (tbl[i]) runVector($sformatf("vec%0d", i), tbl[i], i % 3);

      // Backpressure with in_valid held high across DONE; the held request must be ignored.
      while (!in_ready) begin @(posedge clk); #1; end
      alu_control = 4'd10; src_a = 8'h81; src_b = 8'h00; in_valid = 1'b1;
      @(posedge clk); #1;
      alu_control = 4'd0; src_a = 8'h12; src_b = 8'h34;
      checkOutput("bp out_valid", out_valid, 1);
      bad = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (in_ready || !out_valid || alu_result != 8'h03) bad = 1;
      end
      checkOutput("bp stable", bad, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      checkOutput("bp release ready", in_ready, 1);
      checkOutput("bp release valid", out_valid, 0);
      @(posedge clk); #1;
      checkOutput("bp no stray result", out_valid, 0);

      // Reset in the middle of a multiply must abort it without producing a result.
      alu_control = 4'd2; src_a = 8'hFF; src_b = 8'hFF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checkOutput("midreset in_ready", in_ready, 0);
      rst_n = 1'b1;
      sawValid = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (out_valid) sawValid = 1;
      end
      checkOutput("midreset no out_valid", sawValid, 0);
      checkOutput("midreset ready again", in_ready, 1);

      // Randomized operations against the reference model.
      for (int n = 0; n < 300; n++) begin
         logic [3:0]   op;
         logic [W-1:0] a, b;
         op = 4'($urandom_range(0, 15));
         a  = W'($urandom);
         b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         e  = refModel(op, a, b);
         applyStimulus(op, a, b, $urandom_range(0, 2), o);
         checkOutput($sformatf("rnd%0d op%0d result", n, op), o.res, e.res);
         checkOutput($sformatf("rnd%0d op%0d hi", n, op), o.hi, e.hi);
         checkOutput($sformatf("rnd%0d op%0d flags", n, op), {o.z, o.c, o.d}, {e.z, e.c, e.d});
         checkOutput($sformatf("rnd%0d op%0d latency", n, op), o.lat, e.lat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the core's 8-bit combinational ALU.
- Keeps the same 4-bit operation encoding.
- Adds a valid/ready handshake on both sides, iterative shift-add multiply and restoring divide, full-width products and remainders, and carry/borrow and divide-by-zero flags.
- Sits in the EX stage. The pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH+1), iteration counter width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- src_a  in  WIDTH  operand A
- src_b  in  WIDTH  operand B
- alu_control  in  4  opcode
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- alu_result  out  WIDTH  primary result: low product half or quotient for MUL/DIV
- alu_result_hi  out  WIDTH  MUL high half; DIV remainder; 0 otherwise
- zero  out  1  alu_result == 0
- carry  out  1  ADD carry-out; SUB borrow (A<B unsigned); 0 otherwise
- div_by_zero  out  1  DIV with src_b == 0

Behaviour:
- Reset: sampled on clk when rst_n=0. Drives state=IDLE, counter=0, all outputs 0, and in_ready=0 while rst_n is low.
- Mid-operation reset: reset during BUSY or DONE aborts the operation. No result is produced.

Opcodes (unsigned operands):
- 0 ADD, 1 SUB (A-B mod 2^WIDTH), 2 MUL, 3 DIV, 4 AND, 5 OR, 6 NOT A, 7 XOR.
- 8 SHR A by 1, zero-fill. 9 SHL A by 1, zero-fill.
- 10 ROL A by 1. 11 ROR A by 1.
- 12 GT: result 1 if A>B, else 0. 13 EQ: result 1 if A==B, else 0.
- 14, 15: result 0, all flags 0 (see optional feature).

FSM:
- IDLE: in_ready=1. When in_valid=1, operands and opcode are latched.
  - MUL, or DIV with src_b!=0: go to BUSY, counter=WIDTH.
  - Any other opcode, including DIV with src_b==0: compute, go to DONE.
- BUSY: in_ready=0. One iteration per cycle; counter decrements. On the last iteration (counter==1) go to DONE.
- DONE: out_valid=1. Outputs held stable until out_ready=1, then return to IDLE.
- No overlap. in_ready=0 in DONE even if out_ready=1. Single-cycle ops therefore sustain one result per 2 cycles.

Latency (accept edge to out_valid=1):
- Single-cycle ops: 1 cycle.
- MUL and non-zero DIV: WIDTH+1 cycles.

MUL:
- Shift-add over a 2*WIDTH accumulator.
- {alu_result_hi, alu_result} = A*B, exact.

DIV:
- Restoring division, one quotient bit per cycle.
- alu_result = A/B, alu_result_hi = A%B.
- src_b==0: completes in 1 cycle with alu_result=0, alu_result_hi=src_a, div_by_zero=1.

Flags:
- zero reflects the final alu_result only.
- All flags are registered with the result and valid only while out_valid=1.

Handshake:
- in_valid may be held across DONE. It is ignored until IDLE.
- Operand changes after acceptance have no effect.

Optional Feature:
- Macro: SEQ_ALU_SIGNED_CMP_EN.
- Defined: opcode 14 = signed GT. A and B are two's complement; result 1 if A>B, else 0. Opcode 15 stays reserved (result 0).
- Undefined: opcode 14 is reserved and behaves like 15 (result 0, flags 0). No signed-compare logic is synthesised.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then 1 -> all outputs 0 during reset; in_ready=1 the cycle after release.
- ADD carry, WIDTH=8: A=0xF0, B=0x20, ADD -> out_valid one cycle after accept; alu_result=0x10, carry=1, zero=0. Then SUB A=0x05, B=0x05 -> alu_result=0x00, zero=1, carry=0.
- MUL, WIDTH=8: A=0xFF, B=0xFF -> out_valid exactly 9 cycles after accept; alu_result=0x01, alu_result_hi=0xFE; in_ready=0 throughout.
- DIV, WIDTH=8: A=200, B=7 -> alu_result=28, alu_result_hi=4, latency 9. Then A=0x55, B=0 -> latency 1; alu_result=0, alu_result_hi=0x55, div_by_zero=1.
- Backpressure: ROL A=0x81 with out_ready=0 for 5 cycles -> alu_result=0x03 stable; in_ready=0 throughout. Release -> IDLE next cycle. Reset asserted mid-MUL -> no out_valid produced.
- Signed compare (macro defined), WIDTH=8: opcode 14, A=0x01, B=0xFF -> result 1. Macro undefined -> result 0, all flags 0.
